// File: rtl/i2s_frame_ctrl_if.sv
// i2s_frame_ctrl_if: stereo sample-pair valid/ready handshake into the frame controller
interface i2s_frame_ctrl_if #(parameter int WORD_BITS = 32);
  logic sample_valid;
  logic sample_ready;
  logic [WORD_BITS-1:0] sample_left;
  logic [WORD_BITS-1:0] sample_right;
  modport master (output sample_valid, sample_left, sample_right, input sample_ready);
  modport slave (input sample_valid, sample_left, sample_right, output sample_ready);
endinterface

// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: I2S frame sequencer driving LRCLK, serializer load strobe and parallel word
module i2s_frame_ctrl #(
  parameter int WORD_BITS = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic SCLK,
  input  logic Reset,
  input  logic run,
  input  logic clr_status,
  i2s_frame_ctrl_if.slave smp,
  output logic LRCLK,
  output logic LD,
  output logic [WORD_BITS-1:0] Din,
  output logic underrun,
  output logic [15:0] frame_cnt
);
  localparam int CW = $clog2(2 * WORD_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WORD_BITS - 1);
  localparam logic [CW-1:0] RLOAD = CW'(WORD_BITS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] bit_cnt;
  logic [WORD_BITS-1:0] mem_l [FIFO_DEPTH];
  logic [WORD_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [WORD_BITS-1:0] right_hold;
  logic left_pt, right_pt, empty, push, pop, uflow, start;
  assign smp.sample_ready = count < (AW+1)'(FIFO_DEPTH);
  // bit_cnt rests at LAST in IDLE, so the left load point doubles as the idle load
  always_comb begin
    empty = count == '0;
    left_pt = bit_cnt == LAST;
    right_pt = state == RUN && bit_cnt == RLOAD;
    push = smp.sample_valid && smp.sample_ready;
    pop = left_pt && run && !empty;
    uflow = left_pt && run && empty && state == RUN;
    start = pop || uflow;
    LD = left_pt || right_pt;
    LRCLK = state == RUN && bit_cnt >= RLOAD && bit_cnt != LAST;
    Din = pop ? mem_l[rd_ptr] : right_pt ? right_hold : '0;
  end
  always_ff @(posedge SCLK) begin
    if (Reset) begin
      state <= IDLE;
      bit_cnt <= LAST;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      right_hold <= '0;
      underrun <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (push) begin
        mem_l[wr_ptr] <= smp.sample_left;
        mem_r[wr_ptr] <= smp.sample_right;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (start) begin
        frame_cnt <= frame_cnt + 16'd1;
        right_hold <= pop ? mem_r[rd_ptr] : '0;
      end
      underrun <= uflow || (underrun && !clr_status);
      if (left_pt) begin
        state <= start ? RUN : IDLE;
        bit_cnt <= start ? '0 : LAST;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb_i2s_frame_ctrl: randomized scoreboard bench against a frame-level reference model
module tb_i2s_frame_ctrl;
  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;
  typedef struct packed {
    logic ld;
    logic lr;
    logic rdy;
    logic und;
    logic [15:0] fc;
    logic [31:0] din;
  } obs_t;
  logic SCLK = 0;
  logic Reset, run, clr_status;
  logic LRCLK, LD, underrun;
  logic [31:0] Din;
  logic [15:0] frame_cnt;
  bit armed = 0;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int m_pos;
  bit m_run, m_und;
  logic [31:0] m_rhold;
  logic [15:0] m_fc;
  pair_t mq[$];
  obs_t exp_q[$];
  i2s_frame_ctrl_if #(.WORD_BITS(32)) sif ();
  i2s_frame_ctrl #(.WORD_BITS(32), .FIFO_DEPTH(2)) dut (
    .SCLK(SCLK), .Reset(Reset), .run(run), .clr_status(clr_status), .smp(sif.slave),
    .LRCLK(LRCLK), .LD(LD), .Din(Din), .underrun(underrun), .frame_cnt(frame_cnt)
  );
  always #5 SCLK = ~SCLK;
  task automatic model_reset();
    m_pos = 63;
    m_run = 0;
    m_und = 0;
    m_rhold = 0;
    m_fc = 0;
    mq.delete();
  endtask
  // Frame position m_pos: 0..63 in a running frame, parked at 63 when idle
  always @(negedge SCLK) if (armed) begin
    obs_t e;
    pair_t p;
    bit lp, rp, pop, uf;
    int n;
    n = mq.size();
    lp = m_pos == 63;
    rp = m_run && m_pos == 31;
    pop = lp && run && n > 0;
    uf = lp && run && n == 0 && m_run;
    e.rdy = n < 2;
    e.ld = lp || rp;
    e.lr = m_run && ((m_pos + 1) % 64 >= 32);
    e.din = pop ? mq[0].l : rp ? m_rhold : 32'h0;
    e.und = m_und;
    e.fc = m_fc;
    exp_q.push_back(e);
    if (Reset) model_reset();
    else begin
      if (lp) begin
        if (pop) begin
          m_rhold = mq[0].r;
          void'(mq.pop_front());
        end
        if (uf) m_rhold = 0;
        if (pop || uf) begin
          m_fc++;
          m_pos = 0;
          m_run = 1;
        end else m_run = 0;
      end else m_pos++;
      m_und = uf || (m_und && !clr_status);
      if (sif.sample_valid && n < 2) begin
        p.l = sif.sample_left;
        p.r = sif.sample_right;
        mq.push_back(p);
      end
    end
  end
  always @(negedge SCLK) if (armed) begin
    obs_t g, e;
    #2;
    cyc++;
    g.ld = LD;
    g.lr = LRCLK;
    g.rdy = sif.sample_ready;
    g.und = underrun;
    g.fc = frame_cnt;
    g.din = Din;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle=%0d", cyc);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        fails++;
        $display("FAIL frame_out cycle=%0d got ld=%b lr=%b rdy=%b und=%b fc=%0d din=%h want ld=%b lr=%b rdy=%b und=%b fc=%0d din=%h",
                 cyc, g.ld, g.lr, g.rdy, g.und, g.fc, g.din, e.ld, e.lr, e.rdy, e.und, e.fc, e.din);
      end
    end
  end
  task automatic step(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      sif.sample_valid = v;
      sif.sample_left = $urandom;
      sif.sample_right = $urandom;
      @(posedge SCLK);
      #1;
    end
  endtask
  task automatic wait_pos(input int p, input logic v);
    for (int i = 0; i < 300 && m_pos != p; i++) step(1, v);
    if (m_pos != p) begin
      checks++;
      fails++;
      $display("FAIL wait_pos got=%0d want=%0d", m_pos, p);
    end
  endtask
  initial begin
    Reset = 1;
    run = 0;
    clr_status = 0;
    sif.sample_valid = 0;
    sif.sample_left = 0;
    sif.sample_right = 0;
    model_reset();
    repeat (2) @(posedge SCLK);
    #1;
    armed = 1;
    Reset = 0;
    sif.sample_valid = 1;
    sif.sample_left = 32'hA5A5_0001;
    sif.sample_right = 32'h5A5A_0002;
    @(posedge SCLK);
    #1;
    step(3, 1);
    step(4, 0);
    run = 1;
    step(4 * 64, 1);
    step(3 * 64, 0);
    clr_status = 1;
    step(1, 0);
    clr_status = 0;
    step(40, 0);
    wait_pos(63, 0);
    clr_status = 1;
    step(1, 0);
    clr_status = 0;
    step(10, 0);
    step(1, 1);
    wait_pos(10, 0);
    run = 0;
    step(70, 0);
    for (int i = 0; i < 1500; i++) begin
      clr_status = $urandom_range(0, 40) == 0;
      if ($urandom_range(0, 299) == 0) run = ~run;
      step(1, $urandom_range(0, 3) != 0);
    end
    clr_status = 0;
    run = 1;
    wait_pos(0, 1);
    wait_pos(40, 1);
    Reset = 1;
    step(1, 1);
    Reset = 0;
    step(5, 0);
    step(130, 1);
    @(negedge SCLK);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/i2s_frame_ctrl.md
# i2s_frame_ctrl

Frame sequencer for the I2S serializer: generates LRCLK, the serializer load strobe and the 32-bit parallel word on the bit clock. Stereo sample pairs arrive through a valid/ready handshake into a 2-deep pair FIFO. Runs on the same SCLK as the shift register it drives; LD and Din connect directly to the serializer's LD and Din inputs.

## Interface
- WORD_BITS, 32: slot width in SCLK cycles; equals the serializer width.
- FIFO_DEPTH, 2: sample-pair buffer depth; power of two, at least 2.
- SCLK  in  1  bit clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- run  in  1  1 = stream frames; 0 = stop at the next frame boundary.
- clr_status  in  1  one-cycle pulse; clears underrun.
- sample_valid  in  1  producer has a pair on sample_left/sample_right.
- sample_left  in  WORD_BITS  left-channel word.
- sample_right  in  WORD_BITS  right-channel word.
- sample_ready  out  1  FIFO not full; a pair transfers when valid && ready.
- LRCLK  out  1  word select; 0 = left, 1 = right.
- LD  out  1  serializer load strobe.
- Din  out  WORD_BITS  word to load into the serializer.
- underrun  out  1  sticky: a frame started with an empty FIFO.
- frame_cnt  out  16  frames started; wraps.

## Operation
- Two states: IDLE and RUN. bit_cnt counts 0 to 2*WORD_BITS-1 (call the last value L).
- IDLE: LD=1, Din=0, LRCLK=0, bit_cnt held at L. Serializer continuously loads zeros.
- IDLE to RUN: when run=1 and the FIFO is non-empty. That cycle is a left-load cycle: Din = head.left, LD=1. The controller pops the head, latches head.right into right_hold, increments frame_cnt, and sets bit_cnt to 0.
- RUN, bit_cnt increments each cycle and wraps from L to 0.
- LRCLK=1 for bit_cnt in [WORD_BITS-1, L-1], 0 otherwise. This gives I2S one-bit lead: LRCLK changes one SCLK before each MSB.
- Right load: at bit_cnt == WORD_BITS-1, LD=1 and Din = right_hold.
- Left load (bit_cnt == L):
  - run=0: no pop, LD=1, Din=0, next state IDLE. The current frame always completes.
  - run=1, FIFO non-empty: same action as the IDLE entry; stay in RUN.
  - run=1, FIFO empty: Din=0 and right_hold is set to 0, so the frame is silent. underrun is set and frame_cnt increments. Stay in RUN.
- All other RUN cycles: LD=0, Din = don't-care; drive 0.
- FIFO: sample_ready = (count < FIFO_DEPTH), taken from registered count. There is no bypass:
  - A push into an empty FIFO in a load cycle is not visible until the next frame; that load underruns.
  - A pop from a full FIFO does not raise ready in the same cycle.
- Simultaneous push and pop in one cycle: count unchanged.
- underrun: clr_status clears it. If clr_status and a new underrun event occur in the same cycle, set wins.

## Timing
- Reset values:
  - Outputs: LRCLK=0, LD=1, Din=0, sample_ready=1, underrun=0, frame_cnt=0.
  - Internal: state IDLE, FIFO empty, right_hold=0.
- Reset mid-frame: the next cycle is IDLE and the FIFO is flushed. The partial frame is abandoned.
- LD, LRCLK and Din are combinational from state, bit_cnt and FIFO head; no extra register stage.
- Serializer MSB of left appears at bit_cnt=0 and MSB of right at bit_cnt=WORD_BITS.
- Frame period: exactly 2*WORD_BITS SCLK cycles in RUN. LD pulses exactly twice per frame, at cycles WORD_BITS-1 and L.
- Pair-to-serial latency: a pair accepted at cycle t pops at the first load point at or after t+1.

## Test plan
- Reset, then idle with run=0 and 3 pushes: sample_ready drops after 2 accepted pairs. LD stays 1, Din=0, LRCLK=0, frame_cnt=0.
- Push (L=0xA5A5_0001, R=0x5A5A_0002), then run=1: bit_cnt 0..31 shifts out 0xA5A50001 MSB-first and bit_cnt 32..63 shifts out 0x5A5A0002. LRCLK rises at bit_cnt 31 and falls at 63. frame_cnt=1.
- 4 back-to-back pairs with the producer keeping the FIFO fed: 4 contiguous frames, no idle cycles, underrun=0, frame_cnt=4.
- run=1 with 1 pair, then no pushes: frame 2 is all-zero with underrun=1 and frame_cnt=2. A clr_status pulse then clears underrun; it re-asserts at the next empty load point.
- run drops at bit_cnt=10: the frame completes through bit_cnt=63, then the controller returns to IDLE with LD=1 and Din=0. The FIFO head is not popped.
- Reset asserted at bit_cnt=40 with 2 pairs queued: the next cycle is IDLE with the FIFO empty, sample_ready=1, LRCLK=0 and frame_cnt=0.
